pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h8000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port branch  input  3  branch type from decode: 000 none, 001 jal, 010 jalr, 100 beq, 101 bne, 110 blt/bltu, 111 bge/bgeu; 011 treated as none.
REQ-005 SHALL have port zero  input  1  ALU result == 0.
REQ-006 SHALL have port less  input  1  ALU signed/unsigned less-than, per decode's ALUctr.
REQ-007 SHALL have port imm  input  32  sign-extended immediate from decode.
REQ-008 SHALL have port rs1_data  input  32  register-file read port A.
REQ-009 SHALL have port halt_req  input  1  current instruction is ebreak.
REQ-010 SHALL have port pc  output  32  address of the instruction being fetched and decoded.
REQ-011 SHALL have port pc_valid  output  1  pc is valid for fetch.
REQ-012 SHALL have port pc_ready  input  1  downstream has finished the instruction at pc (retire strobe).
REQ-013 SHALL have port instret  output  64  retired-instruction count.
REQ-014 SHALL have port halted  output  1  core is stopped by ebreak.
REQ-015 SHALL have port misalign  output  1  trap on a misaligned target (see Configuration).

Function
REQ-016 SHALL implement a state machine with states RUN, HALT and TRAP; pc_valid = (state==RUN); halted = (state==HALT); misalign = (state==TRAP).
REQ-017 SHALL treat a cycle where pc_valid && pc_ready as a retire; in any other cycle pc, instret and state SHALL hold.
REQ-018 SHALL sample branch, zero, less, imm and rs1_data only in a retire cycle.
REQ-019 SHALL take the branch when: jal, jalr, beq && zero, bne && !zero, blt && less, or bge && !less.
REQ-020 SHALL compute the target as pc+imm for jal and taken B-type, (rs1_data+imm) & ~32'h1 for jalr, and pc+4 otherwise, all modulo 2^32.
REQ-021 SHALL, on retire in RUN without halt_req, load pc with the target and increment instret by 1, wrapping 2^64-1 to 0.
REQ-022 SHALL, on retire in RUN with halt_req, increment instret, hold pc and enter HALT; halt_req SHALL take priority over branch.
REQ-023 SHALL leave HALT and TRAP only through rst; pc_ready SHALL be ignored in both.
REQ-024 SHALL contain no combinational path from pc_ready or halt_req to pc.

Reset
REQ-025 SHALL, when rst=1 at a rising edge, set pc=RESET_VECTOR, instret=0 and state=RUN, giving pc_valid=1, halted=0 and misalign=0 from the next cycle.
REQ-026 SHALL let rst win over a coincident retire, halt or trap, including when asserted mid-run or in HALT or TRAP.

Configuration
REQ-027 SHALL, with PC_GEN_MISALIGN_TRAP_EN defined, detect a taken target with bits [1:0] != 0 on retire and then: enter TRAP, hold pc at the offending instruction, and not increment instret.
REQ-028 SHALL, with PC_GEN_MISALIGN_TRAP_EN undefined, omit the TRAP state, tie misalign to 0 and load the target unmodified.

Structure
REQ-029 SHALL place the branch-type encodings and the state encoding in the shared package (the same header that holds the imm-type encodings).
REQ-030 SHALL place the branch-condition and target logic in one combinational sub-module, branch_cond; pc_gen SHALL hold all registers.

Verification
REQ-031 SHALL cover reset: rst for 2 cycles -> pc=32'h8000_0000, pc_valid=1, instret=0.
REQ-032 SHALL cover a straight-line stall: branch=000 with pc_ready pattern 1,0,1 -> pc goes 80000000, 80000004, 80000004, 80000008, with instret=2.
REQ-033 SHALL cover branch cases at pc=80000010, imm=-16: bne with zero=1 -> next pc 80000014; blt with less=1 -> next pc 80000000; jalr with rs1=80001003, imm=0 -> next pc 80001002.
REQ-034 SHALL cover halt priority: halt_req=1 with jal in the same cycle -> pc held, halted=1, instret+1; further pc_ready pulses -> no change.
REQ-035 SHALL cover wrap: pc=FFFFFFFC with branch=000 -> pc=00000000; instret preset to all-ones -> instret=0 after retire.
REQ-036 SHALL cover the macro: with it defined, jal at 80000000 with imm=6 -> misalign=1, pc=80000000; with it undefined -> pc=80000006, misalign=0.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared decode encodings (imm types, branch types) and pc_gen FSM states.
// The TRAP state exists only when PC_GEN_MISALIGN_TRAP_EN is defined.
package pc_gen_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_type_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_JAL  = 3'b001,
    BR_JALR = 3'b010,
    BR_RSVD = 3'b011,
    BR_BEQ  = 3'b100,
    BR_BNE  = 3'b101,
    BR_BLT  = 3'b110,
    BR_BGE  = 3'b111
  } branch_e;

`ifdef PC_GEN_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_TRAP = 2'd2
  } pc_state_e;
`else
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1
  } pc_state_e;
`endif

endpackage

// File: rtl/pc_gen_if.sv
// Decode/fetch-side bundle for pc_gen; master drives decode info and the
// retire strobe, slave (pc_gen) returns pc, status and the retire count.
interface pc_gen_if;
  logic [2:0]  branch;
  logic        zero;
  logic        less;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        halt_req;
  logic        pc_ready;
  logic [31:0] pc;
  logic        pc_valid;
  logic [63:0] instret;
  logic        halted;
  logic        misalign;

  modport master (
    output branch, zero, less, imm, rs1_data, halt_req, pc_ready,
    input  pc, pc_valid, instret, halted, misalign
  );

  modport slave (
    input  branch, zero, less, imm, rs1_data, halt_req, pc_ready,
    output pc, pc_valid, instret, halted, misalign
  );
endinterface

// File: rtl/pc_gen_branch_cond.sv
// Combinational branch resolution and next-pc target for pc_gen.
// With PC_GEN_MISALIGN_TRAP_EN defined it also flags a misaligned taken target.
module branch_cond
  import pc_gen_pkg::*;
(
  input  logic [2:0]  branch,
  input  logic        zero,
  input  logic        less,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic [31:0] pc,
  output logic [31:0] target
`ifdef PC_GEN_MISALIGN_TRAP_EN
  , output logic      tgt_misal
`endif
);

  logic taken;

  always_comb begin
    taken = 1'b0;
    case (branch_e'(branch))
      BR_JAL,
      BR_JALR: taken = 1'b1;
      BR_BEQ:  taken = zero;
      BR_BNE:  taken = !zero;
      BR_BLT:  taken = less;
      BR_BGE:  taken = !less;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    target = pc + 32'd4;
    if (taken) begin
      if (branch_e'(branch) == BR_JALR) target = (rs1_data + imm) & ~32'h1;
      else                              target = pc + imm;
    end
  end

`ifdef PC_GEN_MISALIGN_TRAP_EN
  assign tgt_misal = taken && (target[1:0] != 2'b00);
`endif

endmodule

// File: rtl/pc_gen.sv
// Program counter generator: RUN/HALT(/TRAP) FSM, pc and instret registers.
// Optional misaligned-target trap via PC_GEN_MISALIGN_TRAP_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000
) (
  input logic   clk,
  input logic   rst,
  pc_gen_if.slave bus
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [63:0] instret_q, instret_d;
  logic [31:0] target;
  logic        retire;
`ifdef PC_GEN_MISALIGN_TRAP_EN
  logic        tgt_misal;
`endif

  branch_cond u_branch_cond (
    .branch   (bus.branch),
    .zero     (bus.zero),
    .less     (bus.less),
    .imm      (bus.imm),
    .rs1_data (bus.rs1_data),
    .pc       (pc_q),
    .target   (target)
`ifdef PC_GEN_MISALIGN_TRAP_EN
    , .tgt_misal(tgt_misal)
`endif
  );

  assign retire = (state_q == ST_RUN) && bus.pc_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instret_d = instret_q;
    if (retire) begin
      // ebreak retires but freezes pc, regardless of any branch
      if (bus.halt_req) begin
        instret_d = instret_q + 64'd1;
        state_d   = ST_HALT;
      end
`ifdef PC_GEN_MISALIGN_TRAP_EN
      else if (tgt_misal) begin
        state_d = ST_TRAP;
      end
`endif
      else begin
        pc_d      = target;
        instret_d = instret_q + 64'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_VECTOR;
      instret_q <= 64'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.instret  = instret_q;
  assign bus.pc_valid = (state_q == ST_RUN);
  assign bus.halted   = (state_q == ST_HALT);
`ifdef PC_GEN_MISALIGN_TRAP_EN
  assign bus.misalign = (state_q == ST_TRAP);
`else
  assign bus.misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset, stall, branch types, halt, wrap and the
// misaligned-target behaviour in whichever build PC_GEN_MISALIGN_TRAP_EN selects.
module tb_pc_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  pc_gen_if bus ();

  pc_gen #(.RESET_VECTOR(32'h8000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] br, input logic [31:0] im, input logic rdy);
    bus.branch   = br;
    bus.imm      = im;
    bus.pc_ready = rdy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.branch = 3'b000; bus.zero = 1'b0; bus.less = 1'b0; bus.imm = '0;
    bus.rs1_data = '0; bus.halt_req = 1'b0; bus.pc_ready = 1'b0;
    @(negedge clk);

    // reset
    do_reset();
    chk("rst_pc", bus.pc, 64'h8000_0000);
    chk("rst_valid", bus.pc_valid, 1);
    chk("rst_instret", bus.instret, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_misalign", bus.misalign, 0);

    // straight line with stall; branch info during the stall must be ignored
    drive(3'b000, 32'h0, 1'b1); tick();
    chk("seq_pc1", bus.pc, 64'h8000_0004);
    drive(3'b001, 32'h100, 1'b0); tick();
    chk("seq_stall", bus.pc, 64'h8000_0004);
    drive(3'b000, 32'h0, 1'b1); tick();
    chk("seq_pc2", bus.pc, 64'h8000_0008);
    chk("seq_instret", bus.instret, 2);

    // branches
    drive(3'b001, 32'h8, 1'b1); tick();
    chk("jal_fwd", bus.pc, 64'h8000_0010);
    bus.zero = 1'b1;
    drive(3'b101, 32'hFFFF_FFF0, 1'b1); tick();
    chk("bne_nt", bus.pc, 64'h8000_0014);
    drive(3'b001, 32'hFFFF_FFFC, 1'b1); tick();
    chk("jal_back", bus.pc, 64'h8000_0010);
    bus.less = 1'b1;
    drive(3'b110, 32'hFFFF_FFF0, 1'b1); tick();
    chk("blt_t", bus.pc, 64'h8000_0000);
    bus.rs1_data = 32'h8000_1003;
    drive(3'b010, 32'h0, 1'b1); tick();
`ifdef PC_GEN_MISALIGN_TRAP_EN
    // bit1 of the jalr target is set: trap
    chk("jalr_trap", bus.misalign, 1);
    chk("jalr_trap_pc", bus.pc, 64'h8000_0000);
    chk("jalr_trap_inst", bus.instret, 6);
    do_reset();
`else
    chk("jalr", bus.pc, 64'h8000_1002);
    drive(3'b011, 32'h100, 1'b1); tick();
    chk("rsvd_none", bus.pc, 64'h8000_1006);
    bus.zero = 1'b0;
    drive(3'b100, 32'h20, 1'b1); tick();
    chk("beq_nt", bus.pc, 64'h8000_100A);
    bus.less = 1'b0;
    drive(3'b111, 32'hFFFF_FFFE, 1'b1); tick();
    chk("bge_t", bus.pc, 64'h8000_1008);
    chk("br_instret", bus.instret, 10);
`endif

    // pc wrap
    bus.rs1_data = 32'hFFFF_FFFC;
    drive(3'b010, 32'h0, 1'b1); tick();
    chk("jalr_top", bus.pc, 64'hFFFF_FFFC);
    drive(3'b000, 32'h0, 1'b1); tick();
    chk("pc_wrap", bus.pc, 64'h0);

    // instret wrap
    drive(3'b000, 32'h0, 1'b0);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    tick();
    chk("inst_preset", bus.instret, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(3'b000, 32'h0, 1'b1); tick();
    chk("inst_wrap", bus.instret, 0);
    chk("inst_wrap_pc", bus.pc, 64'h4);

    // reset wins over a coincident retire
    rst = 1'b1; drive(3'b001, 32'h40, 1'b1); tick(); rst = 1'b0;
    chk("rst_mid_pc", bus.pc, 64'h8000_0000);
    chk("rst_mid_inst", bus.instret, 0);

    // misaligned jal
    drive(3'b001, 32'h6, 1'b1); tick();
`ifdef PC_GEN_MISALIGN_TRAP_EN
    chk("mis_flag", bus.misalign, 1);
    chk("mis_pc", bus.pc, 64'h8000_0000);
    chk("mis_inst", bus.instret, 0);
    chk("mis_valid", bus.pc_valid, 0);
    drive(3'b000, 32'h0, 1'b1); tick();
    chk("mis_hold", bus.pc, 64'h8000_0000);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mis_rst", bus.misalign, 0);
`else
    chk("mis_pc", bus.pc, 64'h8000_0006);
    chk("mis_flag", bus.misalign, 0);
    chk("mis_inst", bus.instret, 1);
    do_reset();
`endif

    // halt priority over jal
    drive(3'b000, 32'h0, 1'b1); tick();
    chk("h_pre_pc", bus.pc, 64'h8000_0004);
    bus.halt_req = 1'b1;
    drive(3'b001, 32'h40, 1'b1); tick();
    chk("h_pc", bus.pc, 64'h8000_0004);
    chk("h_halted", bus.halted, 1);
    chk("h_valid", bus.pc_valid, 0);
    chk("h_inst", bus.instret, 2);
    bus.halt_req = 1'b0;
    drive(3'b000, 32'h0, 1'b1); tick(); tick();
    chk("h_hold_pc", bus.pc, 64'h8000_0004);
    chk("h_hold_inst", bus.instret, 2);
    chk("h_hold_halted", bus.halted, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("h_rst_halted", bus.halted, 0);
    chk("h_rst_pc", bus.pc, 64'h8000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
